// File: rtl/mpadd_mod_seq.sv
// mpadd_mod_seq
// Requester-side sequencer that drives one external multi-precision adder
// through two operations to form (A+B) mod M, or (A-B) mod M when the
// modular-subtract path is built.
//
// Build option: define MPADD_MODSUB_EN to build the modular-subtract path
// (op=1 selects it). Without the macro, op is ignored, every request is a
// modular add, and the borrow-skip path is not built.
//
// Operands must satisfy A < M, B < M, M < 2^(WIDTH-1). Under that constraint
// the first-step result of an add always fits in WIDTH bits. The second-step
// adder operand register then doubles as the storage for S, so S is not
// kept twice.

module mpadd_mod_seq #(
   parameter int WIDTH   = 1027,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             err,
   output logic             busy,
   output logic             add_start,
   output logic             add_subtract,
   output logic [WIDTH-1:0] add_in_a,
   output logic [WIDTH-1:0] add_in_b,
   input  logic [WIDTH:0]   add_result,
   input  logic             add_done
);

   localparam int CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ1  = 3'd1,
      WAIT1 = 3'd2,
      REQ2  = 3'd3,
      WAIT2 = 3'd4,
      FIN   = 3'd5
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] addInA_q;
   logic [WIDTH-1:0] addInB_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] result_q;
   logic             addStart_q;
   logic             addSub_q;
   logic             done_q;
   logic             err_q;
   logic             busy_q;
   logic [CntW-1:0]  cnt_q;

   logic             subOp_q;
   logic             opSel_d;
   logic             skip_d;
   logic             timeoutHit_d;
   logic [WIDTH-1:0] wait2Result_d;

`ifdef MPADD_MODSUB_EN
   // Request type: op selects modular subtract; a subtract whose first step
   // does not borrow already holds the final answer and skips the second step.
   assign opSel_d = op;
   assign skip_d  = subOp_q & ~add_result[WIDTH];

   // Latch the request type for the duration of the operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         subOp_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         subOp_q <= op;
      end
   end
`else
   // Without the subtract path every request is an add and op has no effect.
   logic unusedOp;
   assign unusedOp = op;
   assign opSel_d  = 1'b0;
   assign skip_d   = 1'b0;
   assign subOp_q  = 1'b0;
`endif

   // The wait counter reaches TIMEOUT-1 on the TIMEOUT-th WAIT cycle after add_start was seen.
   assign timeoutHit_d = (cnt_q == CntW'(TIMEOUT - 1));

   // Second-step result: an add keeps S when S-M borrowed, otherwise S-M; a subtract takes S+M.
   assign wait2Result_d = (!subOp_q && add_result[WIDTH]) ? addInA_q
                                                          : add_result[WIDTH-1:0];

   // Main sequencer: drives the adder handshake and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addInA_q   <= '0;
         addInB_q   <= '0;
         m_q        <= '0;
         result_q   <= '0;
         addStart_q <= 1'b0;
         addSub_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  addInA_q   <= in_a;
                  addInB_q   <= in_b;
                  m_q        <= in_m;
                  addSub_q   <= opSel_d;
                  addStart_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= REQ1;
               end
            end

            REQ1: begin
               addStart_q <= 1'b0;
               cnt_q      <= '0;
               state_q    <= WAIT1;
            end

            WAIT1: begin
               if (add_done) begin
                  if (skip_d) begin
                     result_q <= add_result[WIDTH-1:0];
                     err_q    <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= FIN;
                  end else begin
                     addInA_q   <= add_result[WIDTH-1:0];
                     addInB_q   <= m_q;
                     addSub_q   <= ~subOp_q;
                     addStart_q <= 1'b1;
                     state_q    <= REQ2;
                  end
               end else if (timeoutHit_d) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= FIN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            REQ2: begin
               addStart_q <= 1'b0;
               cnt_q      <= '0;
               state_q    <= WAIT2;
            end

            WAIT2: begin
               if (add_done) begin
                  result_q <= wait2Result_d;
                  err_q    <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= FIN;
               end else if (timeoutHit_d) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= FIN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            FIN: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               addStart_q <= 1'b0;
               done_q     <= 1'b0;
               err_q      <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign result       = result_q;
   assign done         = done_q;
   assign err          = err_q;
   assign busy         = busy_q;
   assign add_start    = addStart_q;
   assign add_subtract = addSub_q;
   assign add_in_a     = addInA_q;
   assign add_in_b     = addInB_q;

endmodule

// File: tb/tb_mpadd_mod_seq.sv
// tb_mpadd_mod_seq
// Scoreboard bench for mpadd_mod_seq with a behavioural adder of programmable
// latency. Expected results, error flags and completion edges are pushed when
// a request is issued; a negedge monitor pops and compares on every done.
// Honors MPADD_MODSUB_EN for the op=1 vectors.
`timescale 1ns/1ps

module tb_mpadd_mod_seq;

   localparam int W  = 1027;
   localparam int TO = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           op;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic [W-1:0]   in_m;
   logic [W-1:0]   result;
   logic           done;
   logic           err;
   logic           busy;
   logic           add_start;
   logic           add_subtract;
   logic [W-1:0]   add_in_a;
   logic [W-1:0]   add_in_b;
   logic [W:0]     add_result = '0;
   logic           add_done   = 1'b0;

   int testsRun    = 0;
   int testsFailed = 0;
   int cyc         = 0;
   int addStarts   = 0;

   int       adderLat  = 2;
   bit       adderMute = 1'b0;
   bit       pending   = 1'b0;
   int       pendCnt   = 0;
   logic [W:0] pendRes = '0;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      int           edgeNo;
   } exp_t;

   exp_t  sbQ[$];
   string nameQ[$];

   always #5 clk = ~clk;

   mpadd_mod_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_m         (in_m),
      .result       (result),
      .done         (done),
      .err          (err),
      .busy         (busy),
      .add_start    (add_start),
      .add_subtract (add_subtract),
      .add_in_a     (add_in_a),
      .add_in_b     (add_in_b),
      .add_result   (add_result),
      .add_done     (add_done)
   );

   // Edge counter and add_start pulse counter, both sampled at the active edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (add_start) addStarts <= addStarts + 1;
   end

   function automatic logic [W:0] adderFn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
      if (sub) return {1'b0, a} - {1'b0, b};
      else     return {1'b0, a} + {1'b0, b};
   endfunction

   // Behavioural adder: add_done is seen adderLat edges after add_start is seen.
   // It ignores reset so that a late completion can reach the sequencer.
   always @(posedge clk) begin
      if (add_done) add_done <= 1'b0;
      if (pending) begin
         if (pendCnt == 1) begin
            add_done   <= 1'b1;
            add_result <= pendRes;
            pending    <= 1'b0;
         end else begin
            pendCnt <= pendCnt - 1;
         end
      end else if (add_start && !adderMute) begin
         if (adderLat == 1) begin
            add_done   <= 1'b1;
            add_result <= adderFn(add_in_a, add_in_b, add_subtract);
         end else begin
            pending <= 1'b1;
            pendCnt <= adderLat - 1;
            pendRes <= adderFn(add_in_a, add_in_b, add_subtract);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
      testsRun = testsRun + 1;
      if (act !== exp) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h (low 64 bits)", name,
                  act[63:0], exp[63:0]);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t  e;
      string n;
      if (done) begin
         if (sbQ.size() == 0) begin
            testsRun    = testsRun + 1;
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL unexpected_done: got done=1 at edge %0d, expected no done",
                     cyc + 1);
         end else begin
            e = sbQ.pop_front();
            n = nameQ.pop_front();
            checkOutput({n, "_result"}, result, e.res);
            checkOutput({n, "_err"}, W'(err), W'(e.err));
            checkOutput({n, "_edge"}, W'(cyc + 1), W'(e.edgeNo));
         end
      end
   end

   // Issue one request; lat is the expected number of edges from acceptance to done.
   task automatic applyStimulus(input string name, input int a, input int b, input int m,
                                input bit opv, input int expRes, input bit expErr,
                                input int lat);
      exp_t e;
      @(negedge clk);
      in_a = '0; in_a[31:0] = a;
      in_b = '0; in_b[31:0] = b;
      in_m = '0; in_m[31:0] = m;
      op    = opv;
      start = 1'b1;
      e.res = '0; e.res[31:0] = expRes;
      e.err = expErr;
      e.edgeNo = cyc + 1 + lat;
      sbQ.push_back(e);
      nameQ.push_back(name);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      testsRun = testsRun + 1;
      if (sbQ.size() != 0) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s_drain: got %0d requests outstanding after %0d cycles, expected 0",
                  name, sbQ.size(), budget);
         sbQ.delete();
         nameQ.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   base;
      exp_t e;
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      in_a  = '0;
      in_b  = '0;
      in_m  = '0;

      // Reset state.
      #12;
      checkOutput("rst_result", result, '0);
      checkOutput("rst_done", W'(done), '0);
      checkOutput("rst_err", W'(err), '0);
      checkOutput("rst_busy", W'(busy), '0);
      checkOutput("rst_add_start", W'(add_start), '0);
      checkOutput("rst_add_in_a", add_in_a, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 5+7 mod 11, with adder handshake checks on both requests.
      in_a = W'(5); in_b = W'(7); in_m = W'(11); op = 1'b0;
      start = 1'b1;
      e.res = W'(1); e.err = 1'b0; e.edgeNo = cyc + 1 + 7;
      sbQ.push_back(e); nameQ.push_back("add_5_7");
      @(negedge clk);
      start = 1'b0;
      checkOutput("t1_busy", W'(busy), W'(1));
      checkOutput("t1_add_start1", W'(add_start), W'(1));
      checkOutput("t1_sub1", W'(add_subtract), W'(0));
      checkOutput("t1_a1", add_in_a, W'(5));
      checkOutput("t1_b1", add_in_b, W'(7));
      repeat (3) @(negedge clk);
      checkOutput("t1_add_start2", W'(add_start), W'(1));
      checkOutput("t1_sub2", W'(add_subtract), W'(1));
      checkOutput("t1_a2", add_in_a, W'(12));
      checkOutput("t1_b2", add_in_b, W'(11));
      waitDrain("add_5_7", 40);
      checkOutput("t1_busy_after", W'(busy), W'(0));

      // Borrow keeps S; exact multiple of M gives zero.
      applyStimulus("add_2_3", 2, 3, 11, 1'b0, 5, 1'b0, 7);
      waitDrain("add_2_3", 40);
      applyStimulus("add_10_1", 10, 1, 11, 1'b0, 0, 1'b0, 7);
      waitDrain("add_10_1", 40);

      // Start held high for 20 cycles: accepted at t0, t0+8, t0+16 only.
      @(negedge clk);
      in_a = W'(1); in_b = W'(1); in_m = W'(3); op = 1'b0;
      start = 1'b1;
      base = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         e.res = W'(2); e.err = 1'b0; e.edgeNo = base + 8 * k + 7;
         sbQ.push_back(e); nameQ.push_back("held_start");
      end
      repeat (20) @(negedge clk);
      start = 1'b0;
      waitDrain("held_start", 40);

      // Adder latency boundaries: 1 cycle and exactly TIMEOUT cycles.
      adderLat = 1;
      applyStimulus("lat1", 10, 1, 11, 1'b0, 0, 1'b0, 5);
      waitDrain("lat1", 40);
      adderLat = TO;
      applyStimulus("lat_max", 5, 7, 11, 1'b0, 1, 1'b0, 2 * TO + 3);
      waitDrain("lat_max", 200);
      adderLat = 2;

      // Adder never answers: timeout with err, then a normal request.
      adderMute = 1'b1;
      applyStimulus("timeout", 1, 1, 3, 1'b0, 0, 1'b1, TO + 2);
      waitDrain("timeout", 120);
      adderMute = 1'b0;
      applyStimulus("after_timeout", 1, 1, 3, 1'b0, 2, 1'b0, 7);
      waitDrain("after_timeout", 40);

      // Reset in WAIT2 aborts; the late add_done must not produce a done.
      adderLat = 5;
      @(negedge clk);
      in_a = W'(5); in_b = W'(7); in_m = W'(11); op = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("abort_busy_before", W'(busy), W'(1));
      #1 reset = 1'b1;
      #1;
      checkOutput("abort_busy", W'(busy), '0);
      checkOutput("abort_done", W'(done), '0);
      checkOutput("abort_add_start", W'(add_start), '0);
      checkOutput("abort_result", result, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("abort_idle", W'(busy), '0);
      adderLat = 2;

      // op=1 vectors: modular subtract when built, otherwise plain modular add.
      base = addStarts;
`ifdef MPADD_MODSUB_EN
      applyStimulus("sub_3_5", 3, 5, 11, 1'b1, 9, 1'b0, 7);
`else
      applyStimulus("op1_3_5", 3, 5, 11, 1'b1, 8, 1'b0, 7);
`endif
      waitDrain("op1_3_5", 40);
      checkOutput("op1_3_5_starts", W'(addStarts - base), W'(2));
      base = addStarts;
`ifdef MPADD_MODSUB_EN
      applyStimulus("sub_5_3", 5, 3, 11, 1'b1, 2, 1'b0, 4);
      waitDrain("sub_5_3", 40);
      checkOutput("sub_5_3_starts", W'(addStarts - base), W'(1));
`else
      applyStimulus("op1_5_3", 5, 3, 11, 1'b1, 8, 1'b0, 7);
      waitDrain("op1_5_3", 40);
      checkOutput("op1_5_3_starts", W'(addStarts - base), W'(2));
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
